// File: rtl/cam_wr_arbiter.sv
// rtl/cam_wr_arbiter.sv - round-robin burst scheduler for camera capture FIFOs
//
// Shares one memory write port among NUM_CH capture channels. A channel becomes
// eligible once its show-ahead FIFO holds a full burst. One channel is granted
// at a time. The block issues a burst command at that channel's current frame
// offset and then drains exactly BURST_LEN words from the granted FIFO.
//
// Ports:
//   clk, rst        sole clock, synchronous active-high reset
//   ch_level        per-channel FIFO fill levels (LVL_W bits each)
//   ch_dout         per-channel show-ahead FIFO heads (16 bits each)
//   ch_frame_start  per-channel start-of-frame pulses (clk domain)
//   ch_rd_en        FIFO pop strobes, at most one bit high
//   wr_req/wr_addr/wr_ack           burst command handshake
//   wr_valid/wr_data/wr_ready/wr_last  burst data handshake
//   grant_id        channel currently granted
//   busy            scheduler not idle
module cam_wr_arbiter #(
    parameter int NUM_CH       = 4,
    parameter int BURST_LEN    = 64,
    parameter int LVL_W        = 10,
    parameter int ADDR_W       = 28,
    parameter int FRAME_WORDS  = 1024*768,
    parameter int FRAME_STRIDE = 2**20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*LVL_W-1:0] ch_level,
    input  logic [NUM_CH*16-1:0]    ch_dout,
    input  logic [NUM_CH-1:0]       ch_frame_start,
    output logic [NUM_CH-1:0]       ch_rd_en,
    output logic                    wr_req,
    output logic [ADDR_W-1:0]       wr_addr,
    input  logic                    wr_ack,
    output logic                    wr_valid,
    output logic [15:0]             wr_data,
    input  logic                    wr_ready,
    output logic                    wr_last,
    output logic [2:0]              grant_id,
    output logic                    busy
);

    localparam int OFF_W = $clog2(FRAME_WORDS);
    localparam int CNT_W = $clog2(BURST_LEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]  offset_q [NUM_CH];
    logic [OFF_W-1:0]  offset_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;

    logic [NUM_CH-1:0]   elig;
    logic [2*NUM_CH-1:0] rot;
    logic                pick_found;
    int                  pick_k;
    logic [2:0]          pick_id;
    logic [OFF_W-1:0]    pick_off;
    logic [OFF_W-1:0]    g_off;
    logic [OFF_W:0]      g_sum;
    logic [OFF_W-1:0]    g_next;
    logic [15:0]         g_dout;
    logic                last_word;

    // Round-robin pick: rotate the eligibility vector so that bit 0 is the
    // channel after the last grant, then take the lowest set bit.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = int'(ch_level[i*LVL_W +: LVL_W]) >= BURST_LEN;
        end
        rot        = {elig, elig} >> (int'(last_grant_q) + 1);
        pick_found = 1'b0;
        pick_k     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!pick_found && rot[k]) begin
                pick_found = 1'b1;
                pick_k     = k;
            end
        end
        pick_id = 3'((int'(last_grant_q) + 1 + pick_k) % NUM_CH);
    end

    // Per-channel selections; a frame start arriving in the same IDLE cycle
    // as the pick must already be reflected in the latched address.
    always_comb begin
        pick_off = '0;
        g_off    = '0;
        g_dout   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == pick_id) begin
                pick_off = ch_frame_start[i] ? '0 : offset_q[i];
            end
            if (3'(i) == grant_q) begin
                g_off  = offset_q[i];
                g_dout = ch_dout[i*16 +: 16];
            end
        end
        g_sum  = {1'b0, g_off} + (OFF_W+1)'(BURST_LEN);
        g_next = (g_sum >= (OFF_W+1)'(FRAME_WORDS)) ? '0 : g_sum[OFF_W-1:0];
    end

    assign last_word = (state_q == S_DATA) && (cnt_q == CNT_W'(BURST_LEN - 1));

    // Frame offsets. A frame start on the channel currently bursting is parked
    // in pend_q and applied in DONE so the running burst keeps its address.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            offset_d[i] = offset_q[i];
            if (ch_frame_start[i]) begin
                if ((3'(i) == grant_q) && ((state_q == S_REQ) || (state_q == S_DATA))) begin
                    pend_d[i] = 1'b1;
                end else begin
                    offset_d[i] = '0;
                    pend_d[i]   = 1'b0;
                end
            end
            if ((state_q == S_DONE) && (3'(i) == grant_q)) begin
                offset_d[i] = (pend_q[i] || ch_frame_start[i]) ? '0 : g_next;
                pend_d[i]   = 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d = S_REQ;
                    grant_d = pick_id;
                    addr_d  = ADDR_W'(pick_id) * ADDR_W'(FRAME_STRIDE) + ADDR_W'(pick_off);
                end
            end
            S_REQ: begin
                cnt_d = '0;
                if (wr_ack) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wr_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= 3'(NUM_CH - 1);
            addr_q       <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                offset_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                offset_q[i] <= offset_d[i];
            end
        end
    end

    // Data path is combinational from state so a show-ahead FIFO pops with
    // zero latency on the same cycle the controller accepts the word.
    always_comb begin
        ch_rd_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rd_en[i] = (state_q == S_DATA) && wr_ready && (3'(i) == grant_q);
        end
    end

    assign wr_req   = (state_q == S_REQ);
    assign wr_addr  = addr_q;
    assign wr_valid = (state_q == S_DATA);
    assign wr_data  = (state_q == S_DATA) ? g_dout : 16'd0;
    assign wr_last  = last_word;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cam_wr_arbiter.sv
// tb/tb_cam_wr_arbiter.sv - directed bench for cam_wr_arbiter
module tb_cam_wr_arbiter;

    localparam int NUM_CH       = 4;
    localparam int BURST_LEN    = 64;
    localparam int LVL_W        = 10;
    localparam int ADDR_W       = 28;
    localparam int FRAME_WORDS  = 256;
    localparam int FRAME_STRIDE = 2**20;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH*LVL_W-1:0] ch_level;
    logic [NUM_CH*16-1:0]    ch_dout;
    logic [NUM_CH-1:0]       ch_frame_start;
    logic [NUM_CH-1:0]       ch_rd_en;
    logic                    wr_req;
    logic [ADDR_W-1:0]       wr_addr;
    logic                    wr_ack;
    logic                    wr_valid;
    logic [15:0]             wr_data;
    logic                    wr_ready;
    logic                    wr_last;
    logic [2:0]              grant_id;
    logic                    busy;

    int pop_cnt [NUM_CH] = '{default: 0};
    int exp_seq [NUM_CH] = '{default: 0};
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cam_wr_arbiter #(
        .NUM_CH(NUM_CH), .BURST_LEN(BURST_LEN), .LVL_W(LVL_W), .ADDR_W(ADDR_W),
        .FRAME_WORDS(FRAME_WORDS), .FRAME_STRIDE(FRAME_STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .ch_level(ch_level), .ch_dout(ch_dout),
        .ch_frame_start(ch_frame_start), .ch_rd_en(ch_rd_en), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_last(wr_last), .grant_id(grant_id), .busy(busy)
    );

    // Show-ahead FIFO model: head word is {channel, pop count}.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_rd_en[i]) pop_cnt[i] <= pop_cnt[i] + 1;
        end
    end

    always_comb begin
        ch_dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_dout[i*16 +: 16] = {4'(i), 12'(pop_cnt[i])};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_level(input int ch, input int v);
        ch_level[ch*LVL_W +: LVL_W] = LVL_W'(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   wr_req,   0);
        check({tag, "_addr"},  wr_addr,  0);
        check({tag, "_valid"}, wr_valid, 0);
        check({tag, "_last"},  wr_last,  0);
        check({tag, "_rd_en"}, ch_rd_en, 0);
        check({tag, "_grant"}, grant_id, 0);
        check({tag, "_busy"},  busy,     0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_ack = 1'b0; wr_ready = 1'b0; ch_level = '0; ch_frame_start = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One burst from request to return to IDLE. sof_at pulses the channel's own
    // frame start at that word index; abort_at returns mid-DATA after that many words.
    task automatic run_burst(input int ch, input logic [31:0] addr, input int ack_dly,
                             input bit toggle, input int sof_at, input int abort_at);
        int  t, hs, bad_data, bad_rd, last_hits, last_at, addr_moves, cyc, pop0;
        bit  sof_done;
        t = 0; hs = 0; bad_data = 0; bad_rd = 0; last_hits = 0; last_at = -1;
        addr_moves = 0; cyc = 0; sof_done = 1'b0;
        wr_ack = 1'b0; wr_ready = 1'b0;
        pop0 = pop_cnt[ch];
        while (!wr_req && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("req_seen", wr_req, 1);
        check("grant", grant_id, ch);
        check("addr", wr_addr, addr);
        for (int k = 0; k < ack_dly; k++) begin
            @(negedge clk);
            if (!wr_req || wr_addr !== addr[ADDR_W-1:0]) addr_moves++;
        end
        check("addr_hold", addr_moves, 0);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        check("req_drop", wr_req, 0);
        check("valid_rise", wr_valid, 1);
        while (hs < BURST_LEN && hs != abort_at && cyc < 2000) begin
            wr_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            ch_frame_start = '0;
            if (!sof_done && hs == sof_at) begin
                ch_frame_start[ch] = 1'b1;
                sof_done = 1'b1;
            end
            #1;
            if (ch_rd_en !== (wr_ready ? 4'(1 << ch) : 4'b0)) bad_rd++;
            if (wr_valid && wr_ready) begin
                if (wr_data !== {4'(ch), 12'(exp_seq[ch])}) bad_data++;
                if (wr_last) begin
                    last_hits++;
                    last_at = hs;
                end
                exp_seq[ch]++;
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        ch_frame_start = '0;
        wr_ready = 1'b0;
        check("data_order", bad_data, 0);
        check("rd_en_shape", bad_rd, 0);
        if (abort_at >= 0 && hs == abort_at) return;
        check("words", hs, BURST_LEN);
        check("pops", pop_cnt[ch] - pop0, BURST_LEN);
        check("last_hits", last_hits, 1);
        check("last_pos", last_at, BURST_LEN - 1);
        check("done_valid", wr_valid, 0);
        check("done_busy", busy, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ch_level = '0; ch_frame_start = '0; wr_ack = 1'b0; wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single channel: two bursts at offsets 0 and 64.
        set_level(0, 64);
        run_burst(0, 0, 0, 1'b0, -1, -1);
        run_burst(0, 64, 0, 1'b0, -1, -1);
        ch_level = '0;

        // Fairness: all channels full.
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_level(i, 200);
        run_burst(0, 0, 0, 1'b0, -1, -1);
        run_burst(1, 32'h0010_0000, 0, 1'b0, -1, -1);
        run_burst(2, 32'h0020_0000, 0, 1'b0, -1, -1);
        run_burst(3, 32'h0030_0000, 0, 1'b0, -1, -1);
        run_burst(0, 64, 0, 1'b0, -1, -1);
        ch_level = '0;

        // Backpressure on first burst, then frame wrap on channel 1.
        do_reset();
        set_level(1, 200);
        run_burst(1, 32'h0010_0000, 5, 1'b1, -1, -1);
        run_burst(1, 32'h0010_0040, 0, 1'b0, -1, -1);
        run_burst(1, 32'h0010_0080, 0, 1'b0, -1, -1);
        run_burst(1, 32'h0010_00C0, 0, 1'b0, -1, -1);
        run_burst(1, 32'h0010_0000, 0, 1'b0, -1, -1);
        ch_level = '0;

        // Frame start during own burst at offset 128 is deferred.
        do_reset();
        set_level(2, 200);
        run_burst(2, 32'h0020_0000, 0, 1'b0, -1, -1);
        run_burst(2, 32'h0020_0040, 0, 1'b0, -1, -1);
        run_burst(2, 32'h0020_0080, 0, 1'b0, 20, -1);
        run_burst(2, 32'h0020_0000, 0, 1'b0, -1, -1);
        ch_level = '0;

        // Frame start on idle channel 3 clears its offset.
        set_level(3, 200);
        run_burst(3, 32'h0030_0000, 0, 1'b0, -1, -1);
        ch_level = '0;
        @(negedge clk);
        ch_frame_start[3] = 1'b1;
        @(negedge clk);
        ch_frame_start = '0;
        set_level(3, 200);
        run_burst(3, 32'h0030_0000, 0, 1'b0, -1, -1);
        ch_level = '0;

        // Reset mid-DATA after 10 words.
        do_reset();
        set_level(0, 200);
        set_level(1, 200);
        run_burst(0, 0, 0, 1'b0, -1, 10);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        check("no_drain", pop_cnt[0], exp_seq[0]);
        rst = 1'b0;
        run_burst(0, 0, 0, 1'b0, -1, -1);
        run_burst(1, 32'h0010_0000, 0, 1'b0, -1, -1);
        ch_level = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_wr_arbiter.md
# cam_wr_arbiter

Round-robin burst scheduler that shares one memory write port among NUM_CH camera capture channels. Each channel's 16-bit pixel stream, after 8-to-16-bit packing, lands in a per-channel show-ahead FIFO. This block watches the FIFO fill levels, grants one channel at a time, issues a fixed-length write burst with a per-channel frame address, and drains exactly BURST_LEN words from the granted FIFO. It sits between the capture FIFOs and the memory controller write interface.

## Interface
- NUM_CH, 4, number of camera channels (2..8)
- BURST_LEN, 64, words per burst (power of two, 8..256)
- LVL_W, 10, width of each FIFO level field
- ADDR_W, 28, word-address width
- FRAME_WORDS, 1024*768, words per frame per channel (multiple of BURST_LEN)
- FRAME_STRIDE, 2**20, word spacing between channel frame buffers

- clk  in  1  memory-side clock; sole clock
- rst  in  1  synchronous, active-high reset
- ch_level  in  NUM_CH*LVL_W  FIFO fill levels; channel i at [i*LVL_W +: LVL_W]
- ch_dout  in  NUM_CH*16  show-ahead FIFO heads; channel i at [i*16 +: 16]
- ch_frame_start  in  NUM_CH  one-cycle pulse per channel, already synchronized to clk
- ch_rd_en  out  NUM_CH  FIFO pop strobes; at most one bit high
- wr_req  out  1  burst command valid
- wr_addr  out  ADDR_W  burst start word address
- wr_ack  in  1  command accepted
- wr_valid  out  1  write data valid
- wr_data  out  16  write data
- wr_ready  in  1  controller accepts data
- wr_last  out  1  marks final word of burst
- grant_id  out  3  channel currently granted
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, REQ, DATA, DONE.
- IDLE: eligible(i) = ch_level[i] >= BURST_LEN. If any channel is eligible, pick the first eligible channel scanning from (last_grant+1) mod NUM_CH upward with wrap. Latch grant_id, then go to REQ.
- REQ: wr_req=1, wr_addr = grant_id*FRAME_STRIDE + offset[grant_id]. Hold both until the cycle wr_req&&wr_ack, then go to DATA.
- DATA: wr_valid=1, wr_data = ch_dout of the granted channel. ch_rd_en[grant_id] = wr_ready.
  - A word counter increments on each wr_valid&&wr_ready.
  - wr_last=1 when counter == BURST_LEN-1.
  - The handshake on the last word moves to DONE.
- DONE (one cycle):
  - offset[grant_id] += BURST_LEN.
  - If the result reaches FRAME_WORDS, it wraps to 0.
  - last_grant <= grant_id, then go to IDLE.
- Offset width is ceil(log2(FRAME_WORDS)). Address arithmetic is unsigned and truncated to ADDR_W.
- ch_frame_start[i] sets pending_sof[i].
  - If channel i is not granted, or the FSM is in IDLE: offset[i] <= 0 on the following cycle and pending_sof[i] clears.
  - If channel i is granted in REQ or DATA, the clear is deferred to DONE. In DONE, offset becomes 0 instead of the increment.
- Simultaneous frame-start pulses on several channels are all honoured independently.
- Eligibility is sampled only in IDLE. Level changes during a burst do not affect it.

## Timing
- Reset values: state=IDLE, wr_req=0, wr_addr=0, wr_valid=0, wr_last=0, ch_rd_en=0, grant_id=0, busy=0, all offsets=0, pending_sof=0, last_grant=NUM_CH-1 (so channel 0 wins first).
- Reset mid-burst aborts immediately. The next cycle shows all reset values, and the FIFO is not drained further.
- IDLE to wr_req high: 1 cycle after an eligible level is seen (registered grant).
- wr_addr is registered and stable from wr_req rise until ack.
- wr_valid rises the cycle after the ack cycle.
- wr_data and ch_rd_en are combinational from the state and wr_ready, giving zero-latency pop for a show-ahead FIFO.
- Minimum burst cost is BURST_LEN+3 cycles (IDLE, REQ with immediate ack, BURST_LEN data cycles, DONE).
- wr_ready low stalls DATA indefinitely with data held. No ch_rd_en is asserted while stalled.

## Test plan
- Single channel: ch_level[0]=64, others 0, immediate ack and ready.
  - Required: one burst at wr_addr=0, exactly 64 pops, wr_last on word 64.
  - Second burst: wr_addr=64.
- Fairness: all four levels held at 200.
  - Required: grants 0,1,2,3,0,…
  - Addresses: 0, 2^20, 2^21, 3*2^20, then 64.
- Backpressure: wr_ack delayed 5 cycles, wr_ready toggling 1/0.
  - Required: wr_addr stable during the ack wait.
  - Exactly 64 ch_rd_en pulses, data order preserved.
- Frame wrap: FRAME_WORDS=256, BURST_LEN=64, channel 1 only.
  - Required: addresses 2^20+0, +64, +128, +192, then back to 2^20+0.
- Frame start during own burst: pulse ch_frame_start[2] mid-DATA while offset is 128.
  - Required: burst completes at +128; the next channel 2 burst uses offset 0.
  - Same pulse on idle channel 3: offset[3]=0 next cycle.
- Reset mid-DATA after 10 words.
  - Required: all outputs return to reset values the next cycle.
  - After reset, channel 0 is granted first, at offset 0.
